// File: rtl/lsc_pkg.sv
// Shared opcodes, size/state encodings and decode helpers for load_store_ctrl.
package lsc_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LUI = 6'b001111;

    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_RESP   = 2'b10
    } state_t;

    typedef struct packed {
        logic  legal;
        logic  load;
        logic  store;
        logic  lui;
        logic  uns;
        size_t size;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d.legal = 1'b1;
        d.load  = 1'b0;
        d.store = 1'b0;
        d.lui   = 1'b0;
        d.uns   = 1'b0;
        d.size  = SZ_WORD;
        case (op)
            OP_LB:  begin d.load = 1'b1; d.size = SZ_BYTE; end
            OP_LBU: begin d.load = 1'b1; d.size = SZ_BYTE; d.uns = 1'b1; end
            OP_LH:  begin d.load = 1'b1; d.size = SZ_HALF; end
            OP_LHU: begin d.load = 1'b1; d.size = SZ_HALF; d.uns = 1'b1; end
            OP_LW:  d.load = 1'b1;
            OP_SB:  begin d.store = 1'b1; d.size = SZ_BYTE; end
            OP_SH:  begin d.store = 1'b1; d.size = SZ_HALF; end
            OP_SW:  d.store = 1'b1;
            OP_LUI: d.lui = 1'b1;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input size_t s, input logic [1:0] off);
        return (s == SZ_HALF && off[0]) || (s == SZ_WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/lsc_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads.
module lsc_align
    import lsc_pkg::*;
(
    input  size_t       st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  size_t       ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_uns,
    input  logic [31:0] rdata,
    output logic [31:0] ldata
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    always_comb begin
        be    = 4'b1111;
        wdata = store_data;
        case (st_size)
            SZ_BYTE: begin
                be    = 4'b0001 << st_off;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = st_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Shift the addressed lane down to bit 0 before extending
    assign byte_sh = rdata >> {ld_off, 3'b000};
    assign half_sh = rdata >> {ld_off[1], 4'b0000};

    always_comb begin
        ldata = rdata;
        case (ld_size)
            SZ_BYTE: ldata = {{24{~ld_uns & byte_sh[7]}}, byte_sh[7:0]};
            SZ_HALF: ldata = {{16{~ld_uns & half_sh[15]}}, half_sh[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_ctrl.sv
// Multi-cycle load/store controller with req/ack memory port and writeback strobe.
// Define LSC_TIMEOUT_EN to enable the ACCESS watchdog (exception code 11).
module load_store_ctrl
    import lsc_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [5:0]        opcode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [15:0]       imm16,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              exc_valid,
    output logic [1:0]        exc_code
);

    state_t      state;
    dec_t        dec;
    size_t       r_size;
    logic [1:0]  r_off;
    logic        r_uns;
    logic        r_load;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;

`ifdef LSC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
`endif

    assign dec      = decode(opcode);
    assign op_ready = (state == S_IDLE);

    lsc_align u_align (
        .st_size    (dec.size),
        .st_off     (addr[1:0]),
        .store_data (store_data),
        .be         (be),
        .wdata      (wdata),
        .ld_size    (r_size),
        .ld_off     (r_off),
        .ld_uns     (r_uns),
        .rdata      (mem_rdata),
        .ldata      (ldata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0;
            mem_wdata <= 32'b0;
            wb_valid  <= 1'b0;
            wb_rd     <= 5'b0;
            wb_data   <= 32'b0;
            exc_valid <= 1'b0;
            exc_code  <= 2'b0;
            r_size    <= SZ_WORD;
            r_off     <= 2'b0;
            r_uns     <= 1'b0;
            r_load    <= 1'b0;
`ifdef LSC_TIMEOUT_EN
            cnt       <= '0;
`endif
        end else begin
            wb_valid  <= 1'b0;
            exc_valid <= 1'b0;
            case (state)
                S_IDLE: if (op_valid) begin
                    wb_rd  <= rd_in;
                    r_off  <= addr[1:0];
                    r_size <= dec.size;
                    r_uns  <= dec.uns;
                    r_load <= dec.load;
                    if (!dec.legal) begin
                        exc_valid <= 1'b1;
                        exc_code  <= EXC_ILLEGAL;
                    end else if (dec.lui) begin
                        wb_data  <= {imm16, 16'h0};
                        wb_valid <= 1'b1;
                        state    <= S_RESP;
                    end else if (misaligned(dec.size, addr[1:0])) begin
                        exc_valid <= 1'b1;
                        exc_code  <= EXC_MISALIGN;
                    end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= dec.store;
                        mem_addr  <= addr[ADDR_W-1:2];
                        mem_be    <= be;
                        mem_wdata <= wdata;
                        state     <= S_ACCESS;
`ifdef LSC_TIMEOUT_EN
                        cnt       <= '0;
`endif
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (r_load) begin
                            wb_data  <= ldata;
                            wb_valid <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
`ifdef LSC_TIMEOUT_EN
                    // Ack on the limit cycle takes priority over the watchdog
                    else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        mem_req   <= 1'b0;
                        exc_valid <= 1'b1;
                        exc_code  <= EXC_TIMEOUT;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed self-checking bench for load_store_ctrl.
module tb_load_store_ctrl;
    import lsc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [15:0] imm16;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    load_store_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .opcode     (opcode),
        .addr       (addr),
        .imm16      (imm16),
        .store_data (store_data),
        .rd_in      (rd_in),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .exc_valid  (exc_valid),
        .exc_code   (exc_code)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] rd);
        opcode     = op;
        addr       = a;
        store_data = sd;
        rd_in      = rd;
        op_valid   = 1'b1;
        tick();
        op_valid   = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [5:0] op,
                           input logic [31:0] a, input logic [31:0] rdata,
                           input int waits, input logic [3:0] xbe,
                           input logic [31:0] xdata);
        mem_rdata = rdata;
        issue(op, a, 32'h0, 5'd7);
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_be"}, 32'(mem_be), 32'(xbe));
        chk({tag, "_addr"}, 32'(mem_addr), a >> 2);
        chk({tag, "_rdy"}, 32'(op_ready), 32'd0);
        repeat (waits) tick();
        if (waits > 0) begin
            chk({tag, "_hold_req"}, 32'(mem_req), 32'd1);
            chk({tag, "_hold_be"}, 32'(mem_be), 32'(xbe));
            chk({tag, "_early_wb"}, 32'(wb_valid), 32'd0);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        chk({tag, "_wbd"}, wb_data, xdata);
        chk({tag, "_wbrd"}, 32'(wb_rd), 32'd7);
        chk({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
        tick();
        chk({tag, "_rdy_back"}, 32'(op_ready), 32'd1);
        chk({tag, "_wb_once"}, 32'(wb_valid), 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [5:0] op,
                            input logic [31:0] a, input logic [31:0] sd,
                            input logic [3:0] xbe, input logic [31:0] xwd);
        issue(op, a, sd, 5'd2);
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_be"}, 32'(mem_be), 32'(xbe));
        chk({tag, "_wd"}, mem_wdata, xwd);
        chk({tag, "_addr"}, 32'(mem_addr), a >> 2);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk({tag, "_rdy_back"}, 32'(op_ready), 32'd1);
        chk({tag, "_no_wb"}, 32'(wb_valid), 32'd0);
        chk({tag, "_reqdrop"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset      = 1'b1;
        op_valid   = 1'b0;
        opcode     = 6'b0;
        addr       = 32'h0;
        imm16      = 16'h0;
        store_data = 32'h0;
        rd_in      = 5'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        tick();
        tick();
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        chk("rst_wd", mem_wdata, 32'd0);
        chk("rst_wbv", 32'(wb_valid), 32'd0);
        chk("rst_wbd", wb_data, 32'd0);
        chk("rst_exc", 32'(exc_valid), 32'd0);
        chk("rst_code", 32'(exc_code), 32'd0);
        reset = 1'b0;
        tick();
        chk("rst_rdy", 32'(op_ready), 32'd1);

        do_load("lb",  OP_LB,  32'h1003, 32'h80FF_1234, 0, 4'b1000, 32'hFFFF_FF80);
        do_load("lhu", OP_LHU, 32'h2002, 32'hBEEF_0000, 3, 4'b1100, 32'h0000_BEEF);
        do_load("lh",  OP_LH,  32'h0000, 32'h1234_8001, 0, 4'b0011, 32'hFFFF_8001);
        do_load("lbu", OP_LBU, 32'h0002, 32'h00F7_0000, 1, 4'b0100, 32'h0000_00F7);
        do_load("lw",  OP_LW,  32'h0004, 32'hCAFE_BABE, 0, 4'b1111, 32'hCAFE_BABE);

        do_store("sb", OP_SB, 32'h0001, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB);
        do_store("sh", OP_SH, 32'h0002, 32'h9999_1357, 4'b1100, 32'h1357_1357);
        do_store("sw", OP_SW, 32'h000C, 32'hA5A5_0F0F, 4'b1111, 32'hA5A5_0F0F);

        imm16 = 16'hDEAD;
        issue(OP_LUI, 32'h0, 32'h0, 5'd9);
        chk("lui_req", 32'(mem_req), 32'd0);
        chk("lui_wbv", 32'(wb_valid), 32'd1);
        chk("lui_wbd", wb_data, 32'hDEAD_0000);
        chk("lui_wbrd", 32'(wb_rd), 32'd9);
        tick();
        chk("lui_rdy", 32'(op_ready), 32'd1);

        issue(OP_LW, 32'h0006, 32'h0, 5'd1);
        chk("mis_exc", 32'(exc_valid), 32'd1);
        chk("mis_code", 32'(exc_code), 32'(EXC_MISALIGN));
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_rdy", 32'(op_ready), 32'd1);
        tick();
        chk("mis_once", 32'(exc_valid), 32'd0);
        chk("mis_req2", 32'(mem_req), 32'd0);

        issue(OP_SH, 32'h0003, 32'h0, 5'd1);
        chk("mis_sh_code", 32'(exc_code), 32'(EXC_MISALIGN));
        chk("mis_sh_req", 32'(mem_req), 32'd0);
        tick();

        issue(6'b000000, 32'h0, 32'h0, 5'd1);
        chk("ill_exc", 32'(exc_valid), 32'd1);
        chk("ill_code", 32'(exc_code), 32'(EXC_ILLEGAL));
        chk("ill_rdy", 32'(op_ready), 32'd1);
        tick();

        issue(OP_LW, 32'h0010, 32'h0, 5'd4);
        chk("rsta_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rsta_drop", 32'(mem_req), 32'd0);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rsta_no_wb", 32'(wb_valid), 32'd0);
        tick();
        chk("rsta_no_wb2", 32'(wb_valid), 32'd0);
        chk("rsta_rdy", 32'(op_ready), 32'd1);

`ifdef LSC_TIMEOUT_EN
        issue(OP_LW, 32'h0020, 32'h0, 5'd4);
        repeat (15) tick();
        chk("to_wait_req", 32'(mem_req), 32'd1);
        chk("to_wait_exc", 32'(exc_valid), 32'd0);
        tick();
        chk("to_exc", 32'(exc_valid), 32'd1);
        chk("to_code", 32'(exc_code), 32'(EXC_TIMEOUT));
        chk("to_req", 32'(mem_req), 32'd0);
        chk("to_rdy", 32'(op_ready), 32'd1);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
